// File: rtl/ifu_pcgen_if.sv
// rtl/ifu_pcgen_if.sv - fetch request channel between the PC generator and the instruction cache
interface ifu_pcgen_if;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        i_ready;
  logic        o_flush;
  logic        o_fencei;

  modport master (
    output o_pc,
    output o_valid,
    output o_flush,
    output o_fencei,
    input  i_ready
  );

  modport slave (
    input  o_pc,
    input  o_valid,
    input  o_flush,
    input  o_fencei,
    output i_ready
  );
endinterface

// File: rtl/ifu_pcgen.sv
// rtl/ifu_pcgen.sv - next-PC generator and fetch-request stage feeding the instruction cache
module ifu_pcgen #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_fencei_req,
  input  logic        i_stall,
  ifu_pcgen_if.master cache,
  output logic        o_misalign,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic        fencei_pending_q, fencei_pending_d;
  logic [31:0] count_q, count_d;

  logic fire;
  logic redirect;
  logic target_aligned;

  assign fire           = valid_q & cache.i_ready;
  assign redirect       = i_redirect_valid & (state_q != ST_BOOT);
  assign target_aligned = (i_redirect_pc[1:0] == 2'b00);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q          <= ST_BOOT;
      pc_q             <= RESET_PC;
      valid_q          <= 1'b0;
      misalign_q       <= 1'b0;
      fencei_pending_q <= 1'b0;
      count_q          <= 32'd0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      valid_q          <= valid_d;
      misalign_q       <= misalign_d;
      fencei_pending_q <= fencei_pending_d;
      count_q          <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    // A fire under redirect is dropped by the cache, so it neither consumes the fence nor counts.
    fencei_pending_d = i_fencei_req | (fencei_pending_q & ~(fire & ~redirect));

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        valid_d = 1'b0;
      end
      ST_RUN, ST_HALT: begin
        if (redirect) begin
          pc_d = i_redirect_pc;
          if (target_aligned) begin
            state_d    = ST_RUN;
            valid_d    = ~i_stall;
            misalign_d = 1'b0;
          end else begin
            state_d    = ST_HALT;
            valid_d    = 1'b0;
            misalign_d = 1'b1;
          end
        end else if (state_q == ST_RUN) begin
          if (fire) begin
            pc_d    = pc_q + PC_STEP;
            count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
          end
          // An outstanding request is never retracted; stall only blocks the next one.
          valid_d = (valid_q & ~fire) | ~i_stall;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  assign cache.o_pc     = pc_q;
  assign cache.o_valid  = valid_q;
  assign cache.o_fencei = valid_q & fencei_pending_q;
  assign cache.o_flush  = i_redirect_valid;
  assign o_misalign     = misalign_q;
  assign o_fetch_count  = count_q;

endmodule

// File: tb/tb_ifu_pcgen.sv
// tb/tb_ifu_pcgen.sv - self-checking bench for ifu_pcgen against a cycle-level reference model
module tb_ifu_pcgen;

  logic        clk;
  logic        rstn;
  logic        rv;
  logic [31:0] rpc;
  logic        fq;
  logic        st;
  logic        o_misalign;
  logic [31:0] o_fetch_count;

  ifu_pcgen_if cache_if ();

  ifu_pcgen dut (
    .i_clock          (clk),
    .i_reset          (rstn),
    .i_redirect_valid (rv),
    .i_redirect_pc    (rpc),
    .i_fencei_req     (fq),
    .i_stall          (st),
    .cache            (cache_if),
    .o_misalign       (o_misalign),
    .o_fetch_count    (o_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what the fetch stage has promised the cache right now.
  bit          m_known = 0;
  bit          m_booting;
  bit          m_halted;
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_mis;
  bit          m_pend;
  longint      m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit fire;
    if (!rstn) begin
      m_known = 1; m_booting = 1; m_halted = 0;
      m_pc = 32'h3000_0000; m_valid = 0; m_mis = 0; m_pend = 0; m_cnt = 0;
    end else if (m_booting) begin
      m_booting = 0;
      m_pend = m_pend | fq;
    end else begin
      fire = m_valid && cache_if.i_ready;
      if (rv) begin
        m_pc = rpc;
        if (rpc % 4 == 0) begin
          m_halted = 0; m_mis = 0; m_valid = !st;
        end else begin
          m_halted = 1; m_mis = 1; m_valid = 0;
        end
      end else if (!m_halted) begin
        if (fire) begin
          m_pc = 32'(m_pc + 4);
          if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
          m_pend = 0;
        end
        m_valid = (m_valid && !fire) || !st;
      end
      m_pend = m_pend | fq;
    end
  endtask

  // Compare all outputs under the current inputs, then advance DUT and model one edge.
  task automatic tick();
    #1;
    chk("flush", {31'd0, cache_if.o_flush}, {31'd0, rv});
    if (m_known) begin
      chk("pc",       cache_if.o_pc, m_pc);
      chk("valid",    {31'd0, cache_if.o_valid}, {31'd0, m_valid});
      chk("fencei",   {31'd0, cache_if.o_fencei}, {31'd0, m_valid & m_pend});
      chk("misalign", {31'd0, o_misalign}, {31'd0, m_mis});
      chk("count",    o_fetch_count, m_cnt[31:0]);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstn = 0; rv = 0; rpc = 0; fq = 0; st = 0; cache_if.i_ready = 1;
    @(negedge clk);
    tick();
    tick();
    #1;
    chk("rst_valid", {31'd0, cache_if.o_valid}, 32'd0);
    chk("rst_pc", cache_if.o_pc, 32'h3000_0000);
    chk("rst_count", o_fetch_count, 32'd0);
    chk("rst_mis", {31'd0, o_misalign}, 32'd0);

    // Boot: valid rises two edges after release, then sequential fires.
    rstn = 1;
    tick();
    chk("boot_valid0", {31'd0, cache_if.o_valid}, 32'd0);
    tick();
    chk("boot_valid1", {31'd0, cache_if.o_valid}, 32'd1);
    chk("seq_pc0", cache_if.o_pc, 32'h3000_0000);
    tick();
    chk("seq_pc1", cache_if.o_pc, 32'h3000_0004);
    tick();
    chk("seq_pc2", cache_if.o_pc, 32'h3000_0008);
    tick();
    chk("seq_count3", o_fetch_count, 32'd3);

    // Back-pressure with toggling stall: request must hold.
    cache_if.i_ready = 0;
    for (int i = 0; i < 4; i++) begin
      st = i[0];
      tick();
      chk("hold_pc", cache_if.o_pc, 32'h3000_000C);
      chk("hold_valid", {31'd0, cache_if.o_valid}, 32'd1);
    end
    cache_if.i_ready = 1; st = 1;
    tick();
    chk("stall_drop", {31'd0, cache_if.o_valid}, 32'd0);
    st = 0;
    tick();
    chk("resume_pc", cache_if.o_pc, 32'h3000_0010);

    // Redirect overriding a fire.
    rv = 1; rpc = 32'h8000_0100;
    tick();
    rv = 0;
    chk("redir_pc", cache_if.o_pc, 32'h8000_0100);
    chk("redir_count", o_fetch_count, 32'd4);

    // Misaligned redirect halts until an aligned one.
    cache_if.i_ready = 0;
    rv = 1; rpc = 32'h8000_0102;
    tick();
    rv = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("halt_mis", {31'd0, o_misalign}, 32'd1);
    chk("halt_valid", {31'd0, cache_if.o_valid}, 32'd0);
    rv = 1; rpc = 32'h8000_0200;
    tick();
    rv = 0;
    chk("unhalt_mis", {31'd0, o_misalign}, 32'd0);
    chk("unhalt_pc", cache_if.o_pc, 32'h8000_0200);
    chk("unhalt_valid", {31'd0, cache_if.o_valid}, 32'd1);

    // fence.i held across back-pressure and a redirect.
    fq = 1;
    tick();
    fq = 0;
    chk("fencei_on", {31'd0, cache_if.o_fencei}, 32'd1);
    tick(); tick();
    rv = 1; rpc = 32'h8000_0300;
    tick();
    rv = 0;
    chk("fencei_redir", {31'd0, cache_if.o_fencei}, 32'd1);
    cache_if.i_ready = 1;
    tick();
    chk("fencei_off", {31'd0, cache_if.o_fencei}, 32'd0);

    // PC wrap.
    rv = 1; rpc = 32'hFFFF_FFFC;
    tick();
    rv = 0;
    tick();
    chk("wrap_pc", cache_if.o_pc, 32'h0000_0000);
    chk("wrap_mis", {31'd0, o_misalign}, 32'd0);

    // Reset mid-burst.
    rstn = 0;
    tick();
    chk("midrst_valid", {31'd0, cache_if.o_valid}, 32'd0);
    chk("midrst_pc", cache_if.o_pc, 32'h3000_0000);
    rstn = 1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cache_if.i_ready = ($urandom_range(0, 3) != 0);
      st   = ($urandom_range(0, 4) == 0);
      fq   = ($urandom_range(0, 15) == 0);
      rv   = ($urandom_range(0, 11) == 0);
      rstn = ($urandom_range(0, 199) != 0);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom() | 32'h1;
        1:       rpc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
        default: rpc = $urandom() & 32'hFFFF_FFFC;
      endcase
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
